// File: rtl/stopwatch_controller.sv
// MM:SS stopwatch: debounced start/clear keys drive an IDLE/RUN/PAUSE FSM that
// counts seconds in BCD and shows them on four active-low 7-segment digits.
module stopwatch_controller #(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic [6:0] D1,
  output logic [6:0] D2,
  output logic [6:0] D3,
  output logic [6:0] D4,
  output logic       running,
  output logic       tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  // Key path, bit 0 = start, bit 1 = clear.
  logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]         db_q, db_d, armed_q, armed_d, press_q, press_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         init_q, init_d;

  state_t             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [3:0]         sec1_q, sec1_d, sec10_q, sec10_d;
  logic [3:0]         min1_q, min1_d, min10_q, min10_d;
  logic               running_q, running_d, tick_q, tick_d;
  logic               tick_c, start_ev, clear_ev;

  always_comb begin
    sync1_d = {key_clear_n, key_start_n};
    sync2_d = sync1_q;
    init_d  = (init_q == 2'd2) ? init_q : init_q + 2'd1;
    db_d    = db_q;
    cnt_d   = '0;
    armed_d = armed_q;
    press_d = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != db_q[k]) begin
        if (cnt_q[k] == DB_MAX) db_d[k] = sync2_q[k];
        else                    cnt_d[k] = cnt_q[k] + CW'(1);
      end
      // A key only arms once it has been seen released after reset, so a key
      // held down through reset cannot fire a press.
      armed_d[k] = armed_q[k] | ((init_q == 2'd2) & sync2_q[k]);
      press_d[k] = db_q[k] & ~db_d[k] & armed_q[k];
    end
  end

  assign start_ev = press_q[0];
  assign clear_ev = press_q[1];
  assign tick_c   = (state_q == RUN) && (presc_q == PRESC_MAX);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec1_d  = sec1_q;
    sec10_d = sec10_q;
    min1_d  = min1_q;
    min10_d = min10_q;
    if (state_q == RUN) begin
      presc_d = tick_c ? '0 : presc_q + PW'(1);
      if (tick_c) begin
        if (sec1_q == 4'd9) begin
          sec1_d = 4'd0;
          if (sec10_q == 4'd5) begin
            sec10_d = 4'd0;
            if (min1_q == 4'd9) begin
              min1_d  = 4'd0;
              min10_d = (min10_q == 4'd5) ? 4'd0 : min10_q + 4'd1;
            end else begin
              min1_d = min1_q + 4'd1;
            end
          end else begin
            sec10_d = sec10_q + 4'd1;
          end
        end else begin
          sec1_d = sec1_q + 4'd1;
        end
      end
    end
    // Clear outranks start when stopped; in RUN only start is honoured.
    case (state_q)
      IDLE, PAUSE: begin
        if (clear_ev) begin
          state_d = IDLE;
          presc_d = '0;
          sec1_d  = 4'd0;
          sec10_d = 4'd0;
          min1_d  = 4'd0;
          min10_d = 4'd0;
        end else if (start_ev) begin
          state_d = RUN;
        end
      end
      RUN:     if (start_ev) state_d = PAUSE;
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    tick_d    = (state_d == RUN) && (presc_d == PRESC_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      db_q      <= 2'b11;
      cnt_q     <= '0;
      armed_q   <= '0;
      press_q   <= '0;
      init_q    <= '0;
      state_q   <= IDLE;
      presc_q   <= '0;
      sec1_q    <= '0;
      sec10_q   <= '0;
      min1_q    <= '0;
      min10_q   <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      press_q   <= press_d;
      init_q    <= init_d;
      state_q   <= state_d;
      presc_q   <= presc_d;
      sec1_q    <= sec1_d;
      sec10_q   <= sec10_d;
      min1_q    <= min1_d;
      min10_q   <= min10_d;
      running_q <= running_d;
      tick_q    <= tick_d;
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  assign D1      = seg(sec1_q);
  assign D2      = seg(sec10_q);
  assign D3      = seg(min1_q);
  assign D4      = seg(min10_q);
  assign running = running_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: scenario tasks compare the DUT against a
// seconds-level model of the stopwatch plus fixed display codes.
module tb_stopwatch_controller;

  localparam int TD = 4;
  localparam int DB = 2;
  localparam logic [27:0] ZERO4 = {4{7'b1000000}};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_start_n = 1'b1;
  logic       key_clear_n = 1'b1;
  logic [6:0] D1, D2, D3, D4;
  logic       running, tick;

  int total = 0;
  int bad   = 0;

  stopwatch_controller #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset_n(reset_n), .key_start_n(key_start_n), .key_clear_n(key_clear_n),
    .D1(D1), .D2(D2), .D3(D3), .D4(D4), .running(running), .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=stopped-cleared, 1=counting, 2=paused.
  int         m_mode, m_frac, m_secs;
  logic [DB:0] m_hist [2];
  logic [1:0] m_db, m_armed, m_ev;
  logic       m_tick, m_running;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [29:0] exp_vec();
    return {seg_of(m_secs / 600), seg_of((m_secs / 60) % 10), seg_of((m_secs % 60) / 10),
            seg_of(m_secs % 10), m_running, m_tick};
  endfunction

  function automatic logic [29:0] dut_vec();
    return {D4, D3, D2, D1, running, tick};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_frac = 0; m_secs = 0;
    m_hist[0] = '1; m_hist[1] = '1;
    m_db = 2'b11; m_armed = 2'b00; m_ev = 2'b00;
    m_tick = 1'b0; m_running = 1'b0;
  endtask

  task automatic model_edge();
    logic [1:0] raw, nev;
    logic       was_tick;
    if (!reset_n) begin
      model_reset();
      return;
    end
    was_tick = (m_mode == 1) && (m_frac == TD - 1);
    if (m_mode == 1) begin
      m_frac = (m_frac + 1) % TD;
      if (was_tick) m_secs = (m_secs + 1) % 3600;
    end
    if (m_mode != 1 && m_ev[1]) begin
      m_mode = 0; m_secs = 0; m_frac = 0;
    end else if (m_ev[0]) begin
      m_mode = (m_mode == 1) ? 2 : 1;
    end
    // Level accepted once the key, seen through two sync stages, disagrees
    // with the accepted level for DB consecutive samples.
    raw = {key_clear_n, key_start_n};
    nev = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (m_hist[k][DB:1] == {DB{~m_db[k]}}) begin
        m_db[k] = ~m_db[k];
        nev[k]  = ~m_db[k] & m_armed[k];
      end
      m_armed[k] = m_armed[k] | raw[k];
      m_hist[k]  = {m_hist[k][DB-1:0], raw[k]};
    end
    m_ev      = nev;
    m_running = (m_mode == 1);
    m_tick    = (m_mode == 1) && (m_frac == TD - 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  // which: 0=start, 1=clear, 2=both
  task automatic press(input int which, input int hold);
    if (which != 1) key_start_n = 1'b0;
    if (which != 0) key_clear_n = 1'b0;
    repeat (hold) cycle();
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    #3;
    total++;
    if ({D4, D3, D2, D1, running, tick} !== {ZERO4, 2'b00}) begin
      bad++; $display("FAIL reset_outputs: got %h want %h", dut_vec(), {ZERO4, 2'b00});
    end
    repeat (3) cycle();
    total++;
    if ({D4, D3, D2, D1, running, tick} !== {ZERO4, 2'b00}) begin
      bad++; $display("FAIL reset_hold: got %h want %h", dut_vec(), {ZERO4, 2'b00});
    end
    reset_n = 1'b1;
    repeat (4) begin
      cycle(); total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL after_reset: got %h want %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_start();
    int n, idx;
    repeat ($urandom_range(2, 6)) begin
      cycle(); total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL idle_wait: got %h want %h", dut_vec(), exp_vec());
      end
    end
    key_start_n = 1'b0;
    n = 0;
    while (running !== 1'b1 && n < 12) begin
      cycle(); n++;
      if (n == 4) key_start_n = 1'b1;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL start_path: got %h want %h", dut_vec(), exp_vec());
      end
    end
    key_start_n = 1'b1;
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL start_running: got %b want 1", running);
    end
    idx = 1;
    while (tick !== 1'b1 && idx < 10) begin
      cycle(); idx++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL first_count: got %h want %h", dut_vec(), exp_vec());
      end
    end
    total++;
    if (idx !== TD) begin
      bad++; $display("FAIL first_tick_latency: got %0d want %0d", idx, TD);
    end
    cycle();
    total++;
    if (D1 !== 7'b1111001) begin
      bad++; $display("FAIL d1_shows_one: got %b want 1111001", D1);
    end
    idx = 1;
    while (tick !== 1'b1 && idx < 10) begin
      cycle(); idx++;
    end
    total++;
    if (idx !== TD) begin
      bad++; $display("FAIL tick_period: got %0d want %0d", idx, TD);
    end
  endtask

  task automatic test_glitch();
    key_start_n = 1'b0;
    cycle();
    key_start_n = 1'b1;
    repeat (8) begin
      cycle(); total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL glitch_path: got %h want %h", dut_vec(), exp_vec());
      end
    end
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL glitch_no_event: got %b want 1", running);
    end
  endtask

  task automatic test_clear_in_run();
    press(1, $urandom_range(3, 6));
    repeat (10) begin
      cycle(); total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL clear_run_path: got %h want %h", dut_vec(), exp_vec());
      end
    end
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL clear_run_ignored: got %b want 1", running);
    end
  endtask

  task automatic test_wrap();
    int n;
    n = 0;
    while (m_secs != 3599 && n < 20000) begin
      cycle(); n++; total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL count_up: got %h want %h", dut_vec(), exp_vec());
      end
    end
    total++;
    if ({D4, D3, D2, D1} !== {seg_of(5), seg_of(9), seg_of(5), seg_of(9)}) begin
      bad++; $display("FAIL show_5959: got %h want %h", {D4, D3, D2, D1},
                      {seg_of(5), seg_of(9), seg_of(5), seg_of(9)});
    end
    n = 0;
    while (tick !== 1'b1 && n < 10) begin
      cycle(); n++;
    end
    cycle();
    total++;
    if ({D4, D3, D2, D1, running} !== {ZERO4, 1'b1}) begin
      bad++; $display("FAIL wrap_0000: got %h want %h", {D4, D3, D2, D1, running}, {ZERO4, 1'b1});
    end
  endtask

  task automatic test_pause_resume();
    int n, idx;
    n = 0;
    while (!(m_running && m_frac == 1) && n < 20) begin
      cycle(); n++;
    end
    key_start_n = 1'b0;
    n = 0;
    while (running !== 1'b0 && n < 12) begin
      cycle(); n++;
      if (n == 4) key_start_n = 1'b1;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL pause_path: got %h want %h", dut_vec(), exp_vec());
      end
    end
    key_start_n = 1'b1;
    total++;
    if (running !== 1'b0) begin
      bad++; $display("FAIL paused: got %b want 0", running);
    end
    repeat (6) begin
      cycle(); total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL pause_hold: got %h want %h", dut_vec(), exp_vec());
      end
    end
    key_start_n = 1'b0;
    n = 0;
    while (running !== 1'b1 && n < 12) begin
      cycle(); n++;
      if (n == 4) key_start_n = 1'b1;
    end
    idx = 1;
    while (tick !== 1'b1 && idx < 10) begin
      cycle(); idx++;
      if (idx == 4) key_start_n = 1'b1;
    end
    key_start_n = 1'b1;
    total++;
    if (idx !== 2) begin
      bad++; $display("FAIL resume_tick_latency: got %0d want 2", idx);
    end
  endtask

  task automatic test_clear_pause();
    press(0, $urandom_range(3, 6));
    repeat (10) cycle();
    total++;
    if (running !== 1'b0) begin
      bad++; $display("FAIL to_pause: got %b want 0", running);
    end
    press(1, $urandom_range(3, 6));
    repeat (10) begin
      cycle(); total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL clear_pause_path: got %h want %h", dut_vec(), exp_vec());
      end
    end
    total++;
    if ({D4, D3, D2, D1, running} !== {ZERO4, 1'b0}) begin
      bad++; $display("FAIL clear_in_pause: got %h want %h", {D4, D3, D2, D1, running}, {ZERO4, 1'b0});
    end
    press(0, $urandom_range(3, 6));
    repeat (12) cycle();
    press(0, $urandom_range(3, 6));
    repeat (10) cycle();
    press(2, $urandom_range(3, 6));
    repeat (10) begin
      cycle(); total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL both_path: got %h want %h", dut_vec(), exp_vec());
      end
    end
    total++;
    if ({D4, D3, D2, D1, running} !== {ZERO4, 1'b0}) begin
      bad++; $display("FAIL both_in_pause: got %h want %h", {D4, D3, D2, D1, running}, {ZERO4, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    int n;
    press(0, 4);
    n = 0;
    while (m_secs != 7 && n < 80) begin
      cycle(); n++; total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL count_to_7: got %h want %h", dut_vec(), exp_vec());
      end
    end
    total++;
    if ({D1, running} !== {7'b1111000, 1'b1}) begin
      bad++; $display("FAIL at_0007: got %h want %h", {D1, running}, {7'b1111000, 1'b1});
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({D4, D3, D2, D1, running, tick} !== {ZERO4, 2'b00}) begin
      bad++; $display("FAIL async_reset: got %h want %h", dut_vec(), {ZERO4, 2'b00});
    end
    model_reset();
    key_start_n = 1'b0;
    repeat (3) cycle();
    reset_n = 1'b1;
    repeat (15) begin
      cycle(); total++;
      if ({running, dut_vec()} !== {1'b0, exp_vec()}) begin
        bad++; $display("FAIL held_key_idle: got %h want %h", {running, dut_vec()}, {1'b0, exp_vec()});
      end
    end
    key_start_n = 1'b1;
    repeat (10) cycle();
    total++;
    if (running !== 1'b0) begin
      bad++; $display("FAIL held_key_release: got %b want 0", running);
    end
    press(0, 4);
    repeat (8) cycle();
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL start_after_reset: got %b want 1", running);
    end
  endtask

  task automatic test_random();
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) key_start_n = ~key_start_n;
      if ($urandom_range(0, 11) == 0) key_clear_n = ~key_clear_n;
      cycle(); total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_keys: got %h want %h", dut_vec(), exp_vec());
      end
    end
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_glitch();
    test_clear_in_run();
    test_wrap();
    test_pause_resume();
    test_clear_pause();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, giving the clk cycles per 1 s count tick (minimum 2).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the clk cycles a synchronized key must stay stable to be accepted (minimum 1).
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, width 1: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port key_start_n, input, width 1: asynchronous start/pause key, active-low.
REQ-006 The block SHALL have port key_clear_n, input, width 1: asynchronous clear key, active-low.
REQ-007 The block SHALL have ports D1, D2, D3 and D4, output, width 7 each: active-low segments {g,f,e,d,c,b,a} showing seconds ones, seconds tens, minutes ones and minutes tens.
REQ-008 The block SHALL have port running, output, width 1: high in state RUN.
REQ-009 The block SHALL have port tick, output, width 1: one-cycle pulse on each count advance.

Function
REQ-010 Each key SHALL pass through a two-flop synchronizer and then a debounce counter.
REQ-011 The debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-012 Any return to the debounced value SHALL restart the debounce count.
REQ-013 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; a key release SHALL generate no event.
REQ-014 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-015 IDLE SHALL go to RUN on a start event.
REQ-016 RUN SHALL go to PAUSE on a start event.
REQ-017 PAUSE SHALL go to RUN on a start event.
REQ-018 In IDLE or PAUSE, a clear event SHALL go to IDLE and zero all digits and the prescaler.
REQ-019 In RUN, a clear event SHALL be ignored.
REQ-020 If start and clear events occur in the same cycle in IDLE or PAUSE, clear SHALL win and the start event SHALL be discarded.
REQ-021 If start and clear events occur in the same cycle in RUN, start SHALL apply: RUN -> PAUSE.
REQ-022 The prescaler (width ceil(log2(TICK_DIV))) SHALL count 0..TICK_DIV-1 only in RUN, hold its value in PAUSE, and be 0 in IDLE.
REQ-023 tick SHALL assert for exactly the one cycle in which the prescaler equals TICK_DIV-1 in RUN, and the prescaler SHALL wrap to 0 on that edge.
REQ-024 The first tick after IDLE->RUN SHALL therefore occur TICK_DIV cycles after the transition edge.
REQ-025 The first tick after PAUSE->RUN SHALL occur after the remaining cycles of the interrupted period; the partial second SHALL NOT be lost or restarted.
REQ-026 Digit registers (4 bits each) SHALL advance on the edge that ends the tick cycle, using BCD cascade: sec_ones 0-9, then sec_tens 0-5, then min_ones 0-9, then min_tens 0-5.
REQ-027 Each digit SHALL carry into the next only when it wraps to 0.
REQ-028 59:59 SHALL wrap to 00:00 while remaining in RUN.
REQ-029 A start event in the tick cycle SHALL NOT suppress that tick's count advance; the state still goes RUN -> PAUSE.
REQ-030 D1..D4 SHALL be combinationally decoded from the registered digits, so a new value appears in the cycle after the tick.
REQ-031 The decode SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-032 Digit codes 10-15 SHALL never occur; if they do, the display SHALL show 1111111 (blank).
REQ-033 running SHALL be a registered decode of the FSM state.

Reset
REQ-034 While reset_n=0, state SHALL be IDLE, with prescaler, digits, debounce counters and synchronizers cleared.
REQ-035 Synchronizers and debounced levels SHALL reset to 1 (key released).
REQ-036 During reset, outputs SHALL be D1..D4=1000000, running=0 and tick=0.
REQ-037 Reset asserted mid-count SHALL take effect immediately, without waiting for clk.
REQ-038 After reset_n deasserts, operation SHALL resume from IDLE on the next rising clk edge; a key held low through reset SHALL NOT produce a press event.

Verification (TICK_DIV=4, DEBOUNCE_CYCLES=2)
REQ-039 The bench SHALL cover: reset, then a start press -> running=1; ticks every 4 cycles; D1 shows 1 (1111001) in the cycle after the first tick.
REQ-040 The bench SHALL cover: a key glitch low for 1 cycle -> no event, state unchanged.
REQ-041 The bench SHALL cover: running, preload 59:59 via ticks -> next tick gives D1..D4 all 1000000 and running still 1.
REQ-042 The bench SHALL cover: start press 2 cycles after a tick -> PAUSE; after a resume press, the next tick arrives 2 cycles after the RUN transition.
REQ-043 The bench SHALL cover: clear press in RUN -> ignored; clear in PAUSE -> IDLE, all digits 0; start and clear pressed together in PAUSE -> IDLE.
REQ-044 The bench SHALL cover: reset_n pulsed low between clk edges while running at 00:07 -> outputs zero immediately; key_start_n held low across reset release -> stays IDLE.
